// File: rtl/superio_regs_pkg.sv
// Shared definitions for the SuperIO register write path: address map, FSM
// states, register indices and small helpers.
package superio_regs_pkg;

  localparam logic [2:0] ADDR_REG1 = 3'b001;
  localparam logic [2:0] ADDR_REG2 = 3'b100;
  localparam logic [2:0] ADDR_REG3 = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    BLOCK,
    ACK
  } state_t;

  typedef enum logic [1:0] {
    REG1_IDX = 2'd0,
    REG2_IDX = 2'd1,
    REG3_IDX = 2'd2
  } reg_idx_t;

  typedef struct packed {
    logic     hit;
    reg_idx_t idx;
  } addr_decode_t;

  function automatic addr_decode_t decode_addr(input logic [2:0] addr);
    addr_decode_t d;
    d.hit = 1'b1;
    d.idx = REG1_IDX;
    case (addr)
      ADDR_REG1: d.idx = REG1_IDX;
      ADDR_REG2: d.idx = REG2_IDX;
      ADDR_REG3: d.idx = REG3_IDX;
      default:   d.hit = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/superio_reg_write_decoder_if.sv
// Avalon-MM style write channel between the QSYS master and the register slave.
interface superio_reg_write_decoder_if #(
  parameter int WIDTH = 32
);

  logic [2:0]         address;
  logic               write;
  logic [WIDTH-1:0]   writedata;
  logic [WIDTH/8-1:0] byteenable;
  logic               waitrequest;

  modport master (
    output address,
    output write,
    output writedata,
    output byteenable,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    input  byteenable,
    output waitrequest
  );

endinterface

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: enabled lanes take the new value, the rest
// keep the old value.
module byte_lane_merge #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   old_value,
  input  logic [WIDTH-1:0]   new_value,
  input  logic [WIDTH/8-1:0] byteenable,
  output logic [WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_value;
    for (int b = 0; b < WIDTH / 8; b++) begin
      if (byteenable[b]) begin
        merged[8*b +: 8] = new_value[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/superio_reg_write_decoder.sv
// Write side of the SuperIO register slave: decodes bus writes into three
// holding registers and hands each update to the ISA side via pending/ack.
module superio_reg_write_decoder
  import superio_regs_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  superio_reg_write_decoder_if.slave  bus,
  output logic [WIDTH-1:0]            reg1Data,
  output logic [WIDTH-1:0]            reg2Data,
  output logic [WIDTH-1:0]            reg3Data,
  output logic [2:0]                  pending,
  input  logic [2:0]                  ack,
  output logic [7:0]                  drop_count
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t             state;
  logic               waitrequest_q;
  logic [2:0]         lat_addr;
  logic [WIDTH-1:0]   lat_data;
  logic [WIDTH/8-1:0] lat_be;
  logic [CW-1:0]      tmo_cnt;

  addr_decode_t       dec;
  logic [WIDTH-1:0]   old_value;
  logic [WIDTH-1:0]   merged_value;
  logic               commit;
  logic [2:0]         set_mask;

  assign dec             = decode_addr(lat_addr);
  assign bus.waitrequest = waitrequest_q;

  always_comb begin
    old_value = reg1Data;
    case (dec.idx)
      REG2_IDX: old_value = reg2Data;
      REG3_IDX: old_value = reg3Data;
      default:  old_value = reg1Data;
    endcase
  end

  byte_lane_merge #(.WIDTH(WIDTH)) u_merge (
    .old_value  (old_value),
    .new_value  (lat_data),
    .byteenable (lat_be),
    .merged     (merged_value)
  );

  // A merge happens on a fresh mapped write to an idle register, or when the
  // consumer finally acknowledges while we are stalled on it.
  always_comb begin
    commit   = 1'b0;
    set_mask = 3'b000;
    case (state)
      DECODE:  commit = dec.hit && (lat_be != '0) && !pending[dec.idx];
      BLOCK:   commit = ack[dec.idx];
      default: commit = 1'b0;
    endcase
    if (commit) begin
      set_mask = 3'b001 << dec.idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg1Data <= '0;
      reg2Data <= '0;
      reg3Data <= '0;
    end else if (commit) begin
      case (dec.idx)
        REG1_IDX: reg1Data <= merged_value;
        REG2_IDX: reg2Data <= merged_value;
        REG3_IDX: reg3Data <= merged_value;
        default:  reg1Data <= reg1Data;
      endcase
    end
  end

  // Transfer FSM; waitrequest is registered so it drops exactly in the ACK cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      waitrequest_q <= 1'b1;
      lat_addr      <= '0;
      lat_data      <= '0;
      lat_be        <= '0;
      tmo_cnt       <= '0;
      pending       <= 3'b000;
      drop_count    <= 8'd0;
    end else begin
      pending <= (pending & ~ack) | set_mask;
      case (state)
        IDLE: begin
          waitrequest_q <= 1'b1;
          if (bus.write) begin
            lat_addr <= bus.address;
            lat_data <= bus.writedata;
            lat_be   <= bus.byteenable;
            state    <= DECODE;
          end
        end
        DECODE: begin
          if (!dec.hit) begin
            drop_count    <= sat_inc8(drop_count);
            state         <= ACK;
            waitrequest_q <= 1'b0;
          end else if ((lat_be == '0) || commit) begin
            state         <= ACK;
            waitrequest_q <= 1'b0;
          end else begin
            tmo_cnt <= '0;
            state   <= BLOCK;
          end
        end
        BLOCK: begin
          if (commit) begin
            state         <= ACK;
            waitrequest_q <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            drop_count    <= sat_inc8(drop_count);
            state         <= ACK;
            waitrequest_q <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        ACK: begin
          waitrequest_q <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          waitrequest_q <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/superio_reg_write_decoder.md
# superio_reg_write_decoder

Write side of the SuperIO QSYS register slave. Accepts Avalon-MM style writes from the QSYS master, decodes the 3-bit address, byte-merges data into three holding registers, and flags each update to the ISA-side consumer with a pending/ack handshake. If a register's previous update is still unacknowledged, the bus transfer stalls via waitrequest, bounded by a timeout. The three register outputs feed the read-side path and the ISA logic.

## Interface
- WIDTH, 32, data width; multiple of 8
- TIMEOUT, 64, max cycles a write may stall on an unacknowledged register; ≥1
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register address from QSYS
- write  in  1  write request; held by master until waitrequest low
- writedata  in  WIDTH  write data
- byteenable  in  WIDTH/8  byte-lane enables
- waitrequest  out  1  stall; transfer completes on a cycle with write=1 and waitrequest=0
- reg1Data, reg2Data, reg3Data  out  WIDTH each  holding registers
- pending  out  3  bit i set: reg(i+1) updated, not yet consumed
- ack  in  3  consumer acknowledge, one bit per register; level-sampled
- drop_count  out  8  saturating count of discarded writes

## Operation
- Address map: 3'b001 → reg1, 3'b100 → reg2, 3'b101 → reg3. All other addresses are unmapped.
- FSM states and transitions:
  - IDLE: write=1 latches address, writedata and byteenable, then goes to DECODE.
  - DECODE:
    - Unmapped address: drop_count+1, then ACK.
    - byteenable all zero: no change, then ACK.
    - Mapped and pending[i]=0: merge, set pending[i], then ACK.
    - Mapped and pending[i]=1: go to BLOCK, clear timeout counter.
  - BLOCK:
    - ack[i]=1: merge, pending[i] stays 1, then ACK.
    - Otherwise the counter increments. When it reaches TIMEOUT-1: discard the write, drop_count+1, then ACK.
  - ACK: one cycle, then IDLE.
- Merge: for each lane b with byteenable[b]=1, reg[8b+7:8b] ← latched writedata lane b. Other lanes hold.
- pending[i] clears on any edge where ack[i]=1, unless the same edge sets it (set wins).
- ack on a register with pending=0 has no effect.
- drop_count saturates at 255.
- Reset (asynchronous, any state): FSM → IDLE, all registers 0, pending 0, drop_count 0, waitrequest 1. An in-flight write is lost and the master reissues it.

## Timing
- waitrequest is registered, equal to (state != ACK); reset value 1.
- Minimum write latency: 3 cycles from write first sampled (IDLE→DECODE→ACK). waitrequest is low in the third cycle.
- Register outputs and pending update on the edge leaving DECODE or BLOCK. They are visible in the ACK cycle.
- Maximum stall in BLOCK: TIMEOUT cycles. Worst-case transfer: TIMEOUT+3 cycles.
- Back-to-back writes: a new write sampled in the IDLE cycle after ACK starts a new transfer, with no dead cycle beyond IDLE.
- Writes are sampled only in IDLE. Changes to address, writedata or byteenable after that are ignored until the next IDLE.
- Simultaneous ack[i] and merge to reg i: data updated, pending[i]=1.

## Structure
- Shared package superio_regs_pkg holds:
  - address constants ADDR_REG1=3'b001, ADDR_REG2=3'b100, ADDR_REG3=3'b101;
  - FSM state type {IDLE, DECODE, BLOCK, ACK};
  - register index type 0..2.
- Sub-module byte_lane_merge (parameter WIDTH; old value, new value, byteenable → merged value), instantiated once on the latched transaction. It is combinational. The FSM, timeout counter and drop counter stay in the top module.

## Test plan
- Write 0xDEADBEEF, be=4'hF, addr 3'b001 → waitrequest low in 3rd cycle; reg1Data=0xDEADBEEF; pending=3'b001.
- reg2=0x11223344 then write 0xAABBCCDD with be=4'b0101 to 3'b100 → reg2Data=0x11BB33DD.
- Write to addr 3'b010 → reg1..3 unchanged; drop_count=1; transfer completes in 3 cycles.
- pending[2]=1, write 0x5 to 3'b101, ack[2] raised 10 cycles later → waitrequest low on the cycle after ack; reg3Data=0x5; pending[2]=1.
- pending[0]=1 with no ack, TIMEOUT=64 → waitrequest low at cycle 67 of the transfer; reg1 unchanged; drop_count increments.
- reset_n low during BLOCK → waitrequest=1, all outputs 0 immediately. After release, a new write to 3'b001 completes normally.
